if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries, which is also the maximum number of requests in flight; legal range 1..4.
REQ-003 clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 jump_flag_i  in  1  redirect request from ex.
REQ-006 jump_addr_i  in  32  redirect target.
REQ-007 ibus_req_o  out  1  fetch request to instruction memory.
REQ-008 ibus_addr_o  out  32  fetch address, word aligned.
REQ-009 ibus_gnt_i  in  1  memory accepts the request in this cycle; meaningful only while ibus_req_o=1.
REQ-010 ibus_rvalid_i  in  1  read data valid; responses return in request order, at least 1 cycle after their grant.
REQ-011 ibus_rdata_i  in  32  instruction word.
REQ-012 inst_valid_o  out  1  buffer head is valid toward if_id/id.
REQ-013 inst_o  out  32  instruction at the buffer head.
REQ-014 inst_addr_o  out  32  address of inst_o.
REQ-015 inst_ready_i  in  1  downstream consumes the head when inst_valid_o=1.

Function
REQ-016 Two-state FSM: BOOT is entered on reset and lasts exactly 1 cycle with ibus_req_o=0; it then goes to RUN permanently until the next reset.
REQ-017 PC register: a grant (ibus_req_o & ibus_gnt_i) advances the PC by 4, and the sum wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-018 ibus_addr_o = PC.
REQ-019 ibus_req_o = RUN & ~jump_flag_i & (occupancy + outstanding < DEPTH).
REQ-020 While a request is ungranted, ibus_addr_o holds stable; the only exception is a jump.
REQ-021 outstanding counter: +1 on grant, -1 on ibus_rvalid_i; a simultaneous grant and response leaves it unchanged.
REQ-022 FIFO of {addr, inst}, DEPTH entries: push on an accepted response, pop on inst_valid_o & inst_ready_i; a simultaneous push and pop keeps occupancy constant, including when the FIFO is full.
REQ-023 REQ-019 guarantees no response arrives while the FIFO is full; such an overflow is an assertion failure.
REQ-024 inst_valid_o = ~empty & ~jump_flag_i.
REQ-025 When the FIFO is empty, inst_o = 32'h0000_0013 (NOP) and inst_addr_o = 0; otherwise both show the head entry.
REQ-026 Jump cycle: the FIFO is emptied at the next edge; the PC loads {jump_addr_i[31:2], 2'b00}; drop_cnt loads the current outstanding value (already net of any response in this cycle); no pop occurs.
REQ-027 Every response arriving while drop_cnt>0 is discarded without a push, and drop_cnt decrements.
REQ-028 A response arriving in the jump cycle itself is also discarded.
REQ-029 New requests may be issued while drop_cnt>0; the total outstanding count still respects DEPTH.
REQ-030 A jump arriving while drop_cnt>0 reloads drop_cnt with the total number of responses then in flight.
REQ-031 Fetch latency: a request issued in cycle t whose response arrives in cycle t+k makes inst_valid_o=1 in cycle t+k+1.

Reset
REQ-032 While rst=1, asynchronously: PC=RESET_PC, FSM=BOOT, outstanding=0, drop_cnt=0, FIFO empty.
REQ-033 While rst=1, outputs are: ibus_req_o=0, inst_valid_o=0, inst_o=32'h0000_0013, inst_addr_o=0.
REQ-034 Reset mid-operation abandons all in-flight requests; the memory side is reset by the same rst, so no late response is delivered.

Verification
REQ-035 Reset release, gnt tied 1, rvalid 1 cycle after grant, ready=1 -> ibus_addr_o steps 0,4,8...; the first inst_valid_o=1 occurs 3 cycles after release with inst_addr_o=0.
REQ-036 inst_ready_i=0 with DEPTH=2 -> exactly 2 grants, then ibus_req_o=0; raising ready resumes fetching, with no instruction lost or duplicated.
REQ-037 ibus_gnt_i=0 for 5 cycles -> ibus_req_o stays 1 and ibus_addr_o stays constant; the grant on cycle 6 advances the PC by 4.
REQ-038 Jump to 32'h0000_1002 with 2 requests outstanding -> the next ibus_addr_o is 32'h0000_1000; the 2 stale responses are dropped; the first delivered inst_addr_o is 32'h0000_1000.
REQ-039 A jump in the same cycle as an rvalid and a pop -> the response is discarded, inst_valid_o=0 that cycle, and the FIFO is empty next cycle.
REQ-040 RESET_PC=32'hFFFF_FFF8, ready=1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in order; rst asserted mid-stream forces all outputs to reset values asynchronously.

Source files
------------

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a small in-order prefetch buffer.
//
// A one-cycle BOOT state follows reset; afterwards the block stays in RUN and
// issues word-aligned fetches from its PC whenever the buffer plus the
// requests already in flight leave room for one more instruction. Responses
// come back in request order and are queued with their address. A jump
// flushes the buffer, redirects the PC and marks every request still in
// flight as stale so that its response is dropped when it arrives.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   jump_flag_i      redirect request from ex
//   jump_addr_i      redirect target (low two bits ignored)
//   ibus_req_o       fetch request toward instruction memory
//   ibus_addr_o      fetch address (current PC)
//   ibus_gnt_i       memory accepts the request this cycle
//   ibus_rvalid_i    read data valid (in request order)
//   ibus_rdata_i     instruction word
//   inst_valid_o     buffer head valid toward decode
//   inst_o           instruction at the buffer head (NOP when empty)
//   inst_addr_o      address of inst_o (0 when empty)
//   inst_ready_i     decode consumes the head
// -----------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  DEPTH_C = 3'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e        state_q;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;   // address of the next response that will be kept
    logic [2:0]    occ_q, occ_d;
    logic [2:0]    out_q, out_d;
    logic [2:0]    drop_q, drop_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   addr_mem_q [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];

    logic          empty_s;
    logic          full_s;
    logic          room_s;
    logic          req_s;
    logic          grant_s;
    logic          push_s;
    logic          pop_s;
    logic          valid_s;
    logic          unused_jump_lsb_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign unused_jump_lsb_s = ^jump_addr_i[1:0];

    // Handshake decode and next-state computation for PC, counters and pointers.
    always_comb begin
        empty_s  = (occ_q == 3'd0);
        full_s   = (occ_q == DEPTH_C);
        // Buffer space must cover every request already in flight plus this one.
        room_s   = (({1'b0, occ_q} + {1'b0, out_q}) < {1'b0, DEPTH_C});
        req_s    = (state_q == RUN) & ~jump_flag_i & room_s;
        grant_s  = req_s & ibus_gnt_i;
        push_s   = ibus_rvalid_i & ~jump_flag_i & (drop_q == 3'd0);
        valid_s  = ~empty_s & ~jump_flag_i;
        pop_s    = valid_s & inst_ready_i;

        out_d    = out_q + {2'b00, grant_s} - {2'b00, ibus_rvalid_i};

        if (jump_flag_i) begin
            pc_d     = {jump_addr_i[31:2], 2'b00};
            rsp_pc_d = {jump_addr_i[31:2], 2'b00};
            // Everything still in flight after this cycle's response is stale.
            drop_d   = out_q - {2'b00, ibus_rvalid_i};
            occ_d    = 3'd0;
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
        end else begin
            pc_d     = grant_s ? (pc_q + 32'd4) : pc_q;
            rsp_pc_d = push_s ? (rsp_pc_q + 32'd4) : rsp_pc_q;
            if (ibus_rvalid_i && (drop_q != 3'd0)) begin
                drop_d = drop_q - 3'd1;
            end else begin
                drop_d = drop_q;
            end
            occ_d    = occ_q + {2'b00, push_s} - {2'b00, pop_s};
            rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        end
    end

    // FSM, PC, counters and buffer pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            occ_q    <= 3'd0;
            out_q    <= 3'd0;
            drop_q   <= 3'd0;
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
        end else begin
            case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     state_q <= RUN;
                default: state_q <= BOOT;
            endcase
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            occ_q    <= occ_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Buffer storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_q[wr_ptr_q] <= rsp_pc_q;
            inst_mem_q[wr_ptr_q] <= ibus_rdata_i;
        end else begin
            addr_mem_q[wr_ptr_q] <= addr_mem_q[wr_ptr_q];
            inst_mem_q[wr_ptr_q] <= inst_mem_q[wr_ptr_q];
        end
    end

    assign ibus_req_o   = req_s;
    assign ibus_addr_o  = pc_q;
    assign inst_valid_o = valid_s;
    assign inst_o       = empty_s ? NOP : inst_mem_q[rd_ptr_q];
    assign inst_addr_o  = empty_s ? 32'h0000_0000 : addr_mem_q[rd_ptr_q];

    // A response can never land on a full buffer unless the head leaves too.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_s && full_s && !pop_s));

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch (RESET_PC=FFFF_FFF8, DEPTH=2).
// A queue-based reference keeps the PC, the list of requests in flight (each
// tagged stale or live) and the buffered instructions; its outputs are
// compared with the DUT every cycle. Directed phases pin key cycles with
// literal values; a long randomized phase follows.
// -----------------------------------------------------------------------------
module tb_if_fetch;

    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;

    if_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_ready_i (inst_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } ent_t;

    int          n_total;
    int          n_pass;
    int          cyc;
    int          grants_seen;
    ent_t        fifo_m[$];
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    bit          mq_stale[$];
    logic [31:0] pc_m;
    bit          boot_m;

    logic        last_req;
    logic        last_valid;
    logic [31:0] last_addr;
    logic [31:0] last_iaddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: actual %h required %h", name, cyc, act, exp);
        end
    endtask

    // Assert reset mid-cycle, check outputs asynchronously, clear the model.
    task automatic do_reset();
        #2 rst = 1'b1;
        jump_flag_i   = 1'b0;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        inst_ready_i  = 1'b0;
        #1;
        chk("rst_req",   32'(ibus_req_o),   32'h0000_0000);
        chk("rst_valid", 32'(inst_valid_o), 32'h0000_0000);
        chk("rst_inst",  inst_o,            NOP);
        chk("rst_iaddr", inst_addr_o,       32'h0000_0000);
        fifo_m.delete();
        mq_addr.delete();
        mq_due.delete();
        mq_stale.delete();
        pc_m        = RPC;
        boot_m      = 1'b1;
        cyc         = 0;
        grants_seen = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cycle(input bit j, input logic [31:0] ja, input bit g, input bit rdy, input int lat);
        bit          rv;
        bit          st;
        bit          push;
        bit          exp_req;
        bit          exp_valid;
        logic [31:0] ra;
        logic [31:0] exp_inst;
        logic [31:0] exp_ia;
        ent_t        e;
        rv = (mq_due.size() > 0) && (mq_due[0] <= cyc);
        jump_flag_i   = j;
        jump_addr_i   = ja;
        ibus_gnt_i    = g;
        inst_ready_i  = rdy;
        ibus_rvalid_i = rv;
        ibus_rdata_i  = rv ? mem_word(mq_addr[0]) : $urandom();
        exp_req   = !boot_m && !j && ((fifo_m.size() + mq_addr.size()) < DEPTH);
        exp_valid = (fifo_m.size() > 0) && !j;
        exp_inst  = (fifo_m.size() > 0) ? fifo_m[0].inst : NOP;
        exp_ia    = (fifo_m.size() > 0) ? fifo_m[0].addr : 32'h0000_0000;
        #1;
        chk("req",   32'(ibus_req_o),   32'(exp_req));
        chk("addr",  ibus_addr_o,       pc_m);
        chk("valid", 32'(inst_valid_o), 32'(exp_valid));
        chk("inst",  inst_o,            exp_inst);
        chk("iaddr", inst_addr_o,       exp_ia);
        last_req   = ibus_req_o;
        last_valid = inst_valid_o;
        last_addr  = ibus_addr_o;
        last_iaddr = inst_addr_o;
        if (ibus_req_o && g) grants_seen++;
        push = 1'b0;
        ra   = 32'h0000_0000;
        st   = 1'b0;
        if (rv) begin
            ra = mq_addr.pop_front();
            void'(mq_due.pop_front());
            st = mq_stale.pop_front();
            push = !j && !st;
        end
        if (exp_valid && rdy) void'(fifo_m.pop_front());
        if (push) begin
            e.addr = ra;
            e.inst = mem_word(ra);
            fifo_m.push_back(e);
        end
        if (j) begin
            fifo_m.delete();
            foreach (mq_stale[i]) mq_stale[i] = 1'b1;
            pc_m = {ja[31:2], 2'b00};
        end else if (exp_req && g) begin
            mq_addr.push_back(pc_m);
            mq_due.push_back(cyc + lat);
            mq_stale.push_back(1'b0);
            pc_m = pc_m + 32'd4;
        end
        boot_m = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        rst           = 1'b1;
        jump_flag_i   = 1'b0;
        jump_addr_i   = 32'h0000_0000;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'h0000_0000;
        inst_ready_i  = 1'b0;
        @(negedge clk);

        // Streaming from a reset PC that wraps through zero.
        do_reset();
        for (int r = 0; r < 12; r++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (r == 0) chk("lit_boot_req", 32'(last_req), 32'h0000_0000);
            if (r == 1) begin
                chk("lit_r1_req",  32'(last_req), 32'h0000_0001);
                chk("lit_r1_addr", last_addr,     32'hFFFF_FFF8);
            end
            if (r == 2) chk("lit_r2_addr", last_addr, 32'hFFFF_FFFC);
            if (r == 3) begin
                chk("lit_r3_addr",  last_addr,       32'h0000_0000);
                chk("lit_r3_valid", 32'(last_valid), 32'h0000_0001);
                chk("lit_r3_iaddr", last_iaddr,      32'hFFFF_FFF8);
            end
        end

        // Back-pressure: exactly DEPTH grants, then fetching resumes.
        do_reset();
        for (int r = 0; r < 28; r++) begin
            cycle(1'b0, 32'h0, 1'b1, (r >= 8), 1);
            if (r == 7) begin
                chk("lit_bp_grants", 32'(grants_seen), 32'd2);
                chk("lit_bp_req",    32'(last_req),    32'h0000_0000);
            end
        end

        // Grant withheld for five cycles.
        do_reset();
        for (int r = 0; r < 15; r++) begin
            cycle(1'b0, 32'h0, (r >= 6), 1'b1, 2);
            if (r == 5) begin
                chk("lit_stall_req",  32'(last_req), 32'h0000_0001);
                chk("lit_stall_addr", last_addr,     32'hFFFF_FFF8);
            end
            if (r == 7) chk("lit_stall_next", last_addr, 32'hFFFF_FFFC);
        end

        // Jump with two requests outstanding.
        do_reset();
        for (int r = 0; r < 18; r++) begin
            cycle((r == 3), 32'h0000_1002, 1'b1, 1'b1, 5);
            if (r == 4) chk("lit_jmp_addr", last_addr, 32'h0000_1000);
            if (r == 6) chk("lit_jmp_drop1", 32'(last_valid), 32'h0000_0000);
            if (r == 7) chk("lit_jmp_drop2", 32'(last_valid), 32'h0000_0000);
            if (r == 13) begin
                chk("lit_jmp_first_valid", 32'(last_valid), 32'h0000_0001);
                chk("lit_jmp_first_iaddr", last_iaddr,      32'h0000_1000);
            end
        end

        // Jump coinciding with a response and a pop.
        do_reset();
        for (int r = 0; r < 10; r++) begin
            cycle((r == 3), 32'h0000_2000, 1'b1, 1'b1, 1);
            if (r == 3) chk("lit_jr_valid", 32'(last_valid), 32'h0000_0000);
            if (r == 4) begin
                chk("lit_jr_empty", 32'(last_valid), 32'h0000_0000);
                chk("lit_jr_addr",  last_addr,       32'h0000_2000);
            end
        end

        // Randomized traffic, each block entered through a mid-stream reset.
        for (int b = 0; b < 4; b++) begin
            do_reset();
            for (int r = 0; r < 400; r++) begin
                cycle(($urandom % 16) == 0, $urandom(),
                      ($urandom % 4) != 0, ($urandom % 4) != 0,
                      int'($urandom_range(1, 4)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
